// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the program counter, issues word
//             requests to a variable-latency instruction memory and presents
//             fetched words through a one-entry IF/ID output register backed
//             by a one-entry skid buffer. Handles downstream stall, branch/jump
//             redirect (with drain of an in-flight request) and counts
//             instructions handed to decode.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   system clock, rising edge
//    rst             in   synchronous active-high reset
//    start_pc        in   PC loaded while rst=1 (word aligned internally)
//    stall           in   decode cannot accept this cycle
//    redirect_valid  in   one-cycle taken branch/jump
//    redirect_pc     in   redirect target (word aligned internally)
//    imem_req        out  request outstanding
//    imem_addr       out  address of outstanding request
//    imem_ack        in   memory data valid this cycle
//    imem_rdata      in   instruction word from memory
//    instr           out  IF/ID instruction
//    instr_pc        out  address of instr
//    instr_valid     out  instr holds a live instruction
//    program_counter out  next fetch address
//    fetch_count     out  instructions delivered to decode (wraps)
// ============================================================================
module if_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] program_counter,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request at pc outstanding
    HOLD  = 2'd1,  // output register and skid both full, no request
    DRAIN = 2'd2   // waiting out a request orphaned by a redirect
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drain_addr;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_data;

  logic req_live;   // request phase, independent of reset gating
  logic ack_eff;    // acks only count while a request is up
  logic consume;    // decode takes the current instruction at this edge
  logic slot_free;  // output register can accept a new word at this edge

  assign req_live  = (state != HOLD);
  assign ack_eff   = imem_ack && req_live;
  assign consume   = instr_valid && !stall;
  assign slot_free = !instr_valid || !stall;

  assign imem_req        = req_live && !rst;
  assign imem_addr       = (state == DRAIN) ? drain_addr : pc;
  assign program_counter = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= start_pc & WORD_MASK;
      state       <= FETCH;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
      drain_addr  <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      // Flush: nothing held is delivered or counted this cycle.
      pc          <= redirect_pc & WORD_MASK;
      instr_valid <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
      case (state)
        FETCH: begin
          // An unanswered request must still be completed by the memory;
          // remember its address so imem_addr stays stable until the ack.
          if (!ack_eff) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
        end
        HOLD:    state <= FETCH;
        default: state <= DRAIN;
      endcase
    end else begin
      if (consume) begin
        fetch_count <= fetch_count + 32'd1;
      end
      case (state)
        FETCH: begin
          if (ack_eff) begin
            pc <= pc + PC_STEP;
            if (slot_free) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
            end else begin
              skid_data <= imem_rdata;
              skid_pc   <= pc;
              state     <= HOLD;
            end
          end else if (consume) begin
            instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          // Output register is consumed this edge; refill from skid so
          // instr_valid stays high without a bubble.
          if (!stall) begin
            instr    <= skid_data;
            instr_pc <= skid_pc;
            state    <= FETCH;
          end
        end
        default: begin
          if (consume) begin
            instr_valid <= 1'b0;
          end
          if (ack_eff) begin
            state <= FETCH;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_unit
//  Purpose  : Self-checking bench for if_fetch_unit. A bench-side memory with
//             programmable wait states answers requests; a queue-based model
//             of the fetch stage is compared against the DUT every cycle, and
//             directed literal checks pin the model on the key scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] start_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] program_counter;
  logic [31:0] fetch_count;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_pc        (start_pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .program_counter (program_counter),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory
  int mem_wait = 0;
  int mem_cnt  = 0;
  bit spurious = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // model: q[0] is what decode sees; a second entry means the stage is full
  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_drain_addr;
  logic [31:0] m_count;
  bit          m_draining;
  bit          m_init = 0;

  function automatic bit m_req();
    return m_init && !rst && (q.size() < 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (m_init) begin
      chk("m_program_counter", program_counter, m_pc);
      chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("m_instr", instr, q[0].d);
        chk("m_instr_pc", instr_pc, q[0].a);
      end
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, m_req()});
      if (m_req()) chk("m_imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
      chk("m_fetch_count", fetch_count, m_count);
    end
  endtask

  // One clock cycle: drive memory response, compare, clock, advance model.
  task automatic step();
    bit          c_rst, c_stall, c_redir, c_ack, c_dreq, c_mreq;
    logic [31:0] c_rpc, c_start;
    #1;
    imem_rdata = mem_word(imem_addr);
    imem_ack   = imem_req ? (mem_cnt >= mem_wait) : spurious;
    #1;
    compare_model();
    c_rst = rst; c_stall = stall; c_redir = redirect_valid; c_ack = imem_ack;
    c_dreq = imem_req; c_mreq = m_req(); c_rpc = redirect_pc; c_start = start_pc;
    @(posedge clk);
    if (c_rst) mem_cnt = 0;
    else if (c_dreq && c_ack) mem_cnt = 0;
    else if (c_dreq) mem_cnt++;
    if (c_rst) begin
      q.delete();
      m_pc = c_start & ~32'd3;
      m_draining = 0;
      m_count = 0;
      m_init = 1;
    end else if (m_init) begin
      if (c_redir) begin
        if (c_mreq && !c_ack && !m_draining) begin
          m_draining   = 1;
          m_drain_addr = m_pc;
        end
        q.delete();
        m_pc = c_rpc & ~32'd3;
      end else begin
        if (q.size() > 0 && !c_stall) begin
          void'(q.pop_front());
          m_count++;
        end
        if (c_mreq && c_ack) begin
          if (m_draining) m_draining = 0;
          else begin
            q.push_back('{d: mem_word(m_pc), a: m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] sp, input int w);
    rst = 1; start_pc = sp; stall = 0; redirect_valid = 0; redirect_pc = 0;
    spurious = 0; mem_wait = w;
    #1;
    chk("req_low_in_reset", {31'd0, imem_req}, 32'd0);
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; start_pc = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_ack = 0; imem_rdata = 0;

    // 0-wait streaming from 624
    do_reset(32'd624, 0);
    chk("rst_pc", program_counter, 32'd624);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    step(); chk("s0_pc0", instr_pc, 32'd624); chk("s0_v0", {31'd0, instr_valid}, 32'd1);
    step(); chk("s0_pc1", instr_pc, 32'd628);
    step(); chk("s0_pc2", instr_pc, 32'd632);
    step(); chk("s0_count3", fetch_count, 32'd3);

    // 2-wait memory
    do_reset(32'd624, 2);
    chk("w2_addr0", imem_addr, 32'd624);
    step(); chk("w2_addr1", imem_addr, 32'd624); chk("w2_pc1", program_counter, 32'd624);
    chk("w2_v1", {31'd0, instr_valid}, 32'd0);
    step(); chk("w2_addr2", imem_addr, 32'd624); chk("w2_pc2", program_counter, 32'd624);
    step(); chk("w2_pc3", program_counter, 32'd628); chk("w2_v3", {31'd0, instr_valid}, 32'd1);
    chk("w2_ipc3", instr_pc, 32'd624);
    step(); chk("w2_v4", {31'd0, instr_valid}, 32'd0);
    step(); step();
    chk("w2_v6", {31'd0, instr_valid}, 32'd1); chk("w2_ipc6", instr_pc, 32'd628);
    chk("w2_pc6", program_counter, 32'd632);

    // stall into HOLD, with stray acks while no request is up
    do_reset(32'd624, 0);
    step(); step(); chk("st_ipc", instr_pc, 32'd628);
    stall = 1; spurious = 1;
    step(); chk("st_req0", {31'd0, imem_req}, 32'd0); chk("st_ipc_h", instr_pc, 32'd628);
    chk("st_pc_h", program_counter, 32'd636);
    step(); step(); step();
    chk("st_ipc_h4", instr_pc, 32'd628); chk("st_instr_h4", instr, mem_word(32'd628));
    chk("st_cnt_h4", fetch_count, 32'd1); chk("st_req_h4", {31'd0, imem_req}, 32'd0);
    stall = 0; spurious = 0;
    step(); chk("st_rel_ipc", instr_pc, 32'd632); chk("st_rel_cnt", fetch_count, 32'd2);
    chk("st_rel_v", {31'd0, instr_valid}, 32'd1);
    step(); chk("st_nxt_ipc", instr_pc, 32'd636); chk("st_nxt_cnt", fetch_count, 32'd3);

    // redirect while a 3-wait request to 640 is outstanding
    do_reset(32'd624, 0);
    repeat (4) step();
    chk("rd_pre_pc", program_counter, 32'd640); chk("rd_pre_cnt", fetch_count, 32'd3);
    mem_wait = 3; stall = 1;
    step(); chk("rd_addr0", imem_addr, 32'd640); chk("rd_v0", {31'd0, instr_valid}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'd1001;
    step();
    redirect_valid = 0; stall = 0;
    chk("rd_flush_v", {31'd0, instr_valid}, 32'd0); chk("rd_pc", program_counter, 32'd1000);
    chk("rd_addr_hold", imem_addr, 32'd640); chk("rd_cnt", fetch_count, 32'd3);
    step(); chk("rd_addr_hold2", imem_addr, 32'd640);
    step(); chk("rd_addr_new", imem_addr, 32'd1000); chk("rd_v_drop", {31'd0, instr_valid}, 32'd0);
    chk("rd_cnt2", fetch_count, 32'd3);
    repeat (4) step();
    chk("rd_tgt_v", {31'd0, instr_valid}, 32'd1); chk("rd_tgt_ipc", instr_pc, 32'd1000);
    chk("rd_cnt3", fetch_count, 32'd3);

    // redirect coincident with ack while stalled
    do_reset(32'd624, 0);
    step();
    stall = 1; redirect_valid = 1; redirect_pc = 32'd2000;
    step();
    redirect_valid = 0; stall = 0;
    chk("rc_v", {31'd0, instr_valid}, 32'd0); chk("rc_req", {31'd0, imem_req}, 32'd1);
    chk("rc_addr", imem_addr, 32'd2000); chk("rc_cnt", fetch_count, 32'd0);
    step(); chk("rc_ipc", instr_pc, 32'd2000); chk("rc_instr", instr, mem_word(32'd2000));

    // reset in the middle of a wait
    do_reset(32'd624, 0);
    repeat (3) step();
    mem_wait = 2;
    step();
    rst = 1; start_pc = 32'd0;
    #1; chk("mr_req_rst", {31'd0, imem_req}, 32'd0);
    step();
    rst = 0;
    chk("mr_v", {31'd0, instr_valid}, 32'd0); chk("mr_cnt", fetch_count, 32'd0);
    chk("mr_pc", program_counter, 32'd0);
    step(); step(); step();
    chk("mr_ipc", instr_pc, 32'd0); chk("mr_v2", {31'd0, instr_valid}, 32'd1);

    // misaligned start and pc wrap
    do_reset(32'hFFFF_FFFF, 0);
    chk("wr_pc", program_counter, 32'hFFFF_FFFC);
    step(); chk("wr_ipc", instr_pc, 32'hFFFF_FFFC); chk("wr_pc2", program_counter, 32'd0);
    step(); chk("wr_ipc2", instr_pc, 32'd0);

    // mixed stall / redirect / stray-ack pattern, model-checked only
    do_reset(32'h0000_0100, 1);
    for (int i = 0; i < 40; i++) begin
      stall          = (i % 5 == 1) || (i % 5 == 2);
      redirect_valid = (i == 17) || (i == 30);
      redirect_pc    = 32'h3000 + 32'(i * 8) + 32'd1;
      spurious       = (i % 4 == 3);
      step();
    end
    stall = 0; redirect_valid = 0; spurious = 0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the MIPS core, directly upstream of decode and the register file. Holds the program counter, which loads a start address under reset. Issues word requests to a variable-latency instruction memory and presents fetched instructions through a one-entry IF/ID output register. Supports a downstream stall, a branch/jump redirect that flushes in-flight work, and a delivered-instruction counter for bench cycle checks.

Parameters:
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_pc  in  ADDR_W  PC loaded while rst=1; bits [1:0] forced to 0
- stall  in  1  decode cannot accept this cycle
- redirect_valid  in  1  one-cycle branch/jump taken
- redirect_pc  in  ADDR_W  target; bits [1:0] forced to 0
- imem_req  out  1  request outstanding
- imem_addr  out  ADDR_W  address of outstanding request
- imem_ack  in  1  data valid this cycle
- imem_rdata  in  DATA_W  instruction word
- instr  out  DATA_W  IF/ID instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr holds a live instruction
- program_counter  out  ADDR_W  next fetch address (pc register)
- fetch_count  out  32  instructions delivered to decode

Behaviour:
- Reset (rst=1 at edge): pc<=start_pc&~3, state<=FETCH, instr_valid<=0, instr<=0, instr_pc<=0, skid cleared, fetch_count<=0. imem_req=0 during the reset cycle. rst overrides everything, including mid-request; any later ack for a pre-reset request is the memory's responsibility (memory is reset by the same rst).
- Priority at each edge: rst > redirect_valid > ack/consume.
- Delivery: the instruction is consumed when instr_valid && !stall. Slot free = !instr_valid || !stall.
- Memory protocol: imem_req held high with imem_addr stable until the cycle imem_ack=1. ack may arrive in the first req cycle (0-wait) or any later cycle. ack with req=0 is ignored.
- FETCH state:
  - imem_req=1, imem_addr=pc.
  - On ack with slot free: instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4. Stay in FETCH; the next request is issued the following cycle (1 instr/cycle with 0-wait memory).
  - On ack with slot not free: skid<=(rdata,pc), pc<=pc+4, go to HOLD.
  - No ack and consume: instr_valid<=0.
- HOLD state:
  - imem_req=0.
  - When stall=0: the output register takes the skid entry (instr_valid stays 1) and the state returns to FETCH.
- DRAIN state:
  - imem_req=1, imem_addr=latched old address.
  - On ack: data discarded, go to FETCH.
- Redirect (redirect_valid=1):
  - pc<=redirect_pc&~3, instr_valid<=0 (flush), skid discarded.
  - Next state: from FETCH without ack -> DRAIN (old address latched). From FETCH with ack in the same cycle -> FETCH, and the acked data is discarded. From HOLD -> FETCH. From DRAIN -> DRAIN, with pc updated.
  - A flushed instruction is never counted.
- pc+4 wraps modulo 2^ADDR_W.
- fetch_count increments on each consume and wraps at 2^32.
- Latency: ack at edge N puts instr_valid=1 after edge N.
- program_counter reflects pc after every edge.

Test Plan:
- rst=1 with start_pc=624, then 0-wait memory, stall=0 -> program_counter=624 after reset. instr_pc sequence 624, 628, 632 on consecutive cycles; fetch_count=3 after 3 deliveries.
- 2-wait memory (ack 2 cycles after req) -> imem_addr held at 624 for 3 cycles. instr_valid pulses once per 3 cycles; program_counter 624 -> 628 only at the ack edge.
- stall=1 for 4 cycles while instr_pc=628 is valid and 632 is acked -> HOLD entered, instr stays at 628, imem_req=0. On release, 628 consumed then 632 delivered next cycle; no loss or duplication.
- redirect_valid with redirect_pc=1001 while a 3-wait request to 640 is outstanding -> instr_valid=0 next cycle. imem_addr stays 640 until ack, that data is discarded, then a request goes to 1000. fetch_count is unchanged by the flush.
- redirect coincident with ack and stall=1 -> acked data dropped, no HOLD entered, next imem_addr = target.
- rst asserted mid-wait with start_pc=0 -> instr_valid=0, fetch_count=0, program_counter=0 after that edge; fetch restarts at 0.
